mul_div_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 32 +++
 rtl/mdu_iter_core.sv | 67 ++++++
 rtl/mul_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multiply/divide unit.
//   - Op codes seen on mul_div_unit.op
//   - Sequencer state encoding
//   - ITER: number of RUN iterations, one per operand bit
//   - is_muldiv(): true for the four iterative operations
package mips_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one-bit-per-cycle datapath shared by multiply and divide.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : initialise acc to {0, init_lo}
//   step       : perform one iteration
//   is_div     : 1 = restoring divide step, 0 = shift-add multiply step
//   init_lo    : multiplier (mul) or dividend (div) magnitude
//   operand    : multiplicand (mul) or divisor (div) magnitude, held stable
//   acc        : 64-bit accumulator; mul -> product, div -> {rem, quot}
module mdu_iter_core
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     init_lo,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;

    // Next accumulator value for one multiply or divide iteration
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // 33-bit partial remainder: old remainder shifted with next dividend bit
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, operand};
        acc_next_s  = acc_r;
        if (is_div) begin
            // Non-negative difference: subtract succeeds, quotient bit is 1.
            // Either way the kept remainder is below the divisor, so it fits WIDTH bits.
            if (!div_diff_s[WIDTH+1]) begin
                acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Product bits shift in from the top as multiplier bits leave the bottom
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {(2*WIDTH){1'b0}};
        end else if (load) begin
            acc_r <= {{WIDTH{1'b0}}, init_lo};
        end else if (step) begin
            acc_r <= acc_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, plus MTHI/MTLO.
//   clk, rst_n : clock, synchronous active-low reset
//   start, op  : request strobe and operation (sampled only when idle)
//   src_a      : rs value (multiplicand / dividend / MTHI-MTLO data)
//   src_b      : rt value (multiplier / divisor)
//   busy       : high while a mul/div is in flight (33 cycles)
//   done       : one-cycle pulse after HI/LO is written
//   hi, lo     : architectural HI/LO registers
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   b_mag_r;
    logic               is_div_r;
    logic               sign_q_r;   // product / quotient negative
    logic               sign_r_r;   // remainder negative
    logic               dbz_r;      // divide by zero

    logic               load_s;
    logic               step_s;
    logic               signed_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] acc_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Operand magnitudes and datapath control strobes
    always_comb begin
        signed_s = is_signed_op(op);
        if (signed_s && src_a[WIDTH-1]) begin
            a_mag_s = {WIDTH{1'b0}} - src_a;
        end else begin
            a_mag_s = src_a;
        end
        if (signed_s && src_b[WIDTH-1]) begin
            b_mag_s = {WIDTH{1'b0}} - src_b;
        end else begin
            b_mag_s = src_b;
        end
        load_s = (state_r == ST_IDLE) && start && is_muldiv(op);
        step_s = (state_r == ST_RUN);
    end

    mdu_iter_core #(
        .WIDTH   (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .step    (step_s),
        .is_div  (is_div_r),
        .init_lo (a_mag_s),
        .operand (b_mag_r),
        .acc     (acc_s)
    );

    // Sign correction of the raw magnitudes for the FIX cycle
    always_comb begin
        prod_s = sign_q_r ? ({(2*WIDTH){1'b0}} - acc_s) : acc_s;
        quot_s = sign_q_r ? ({WIDTH{1'b0}} - acc_s[WIDTH-1:0]) : acc_s[WIDTH-1:0];
        // For a zero divisor the remainder magnitude is |src_a|; restoring the
        // dividend's sign reproduces src_a exactly, including 0x80000000.
        rem_s  = sign_r_r ? ({WIDTH{1'b0}} - acc_s[2*WIDTH-1:WIDTH]) : acc_s[2*WIDTH-1:WIDTH];
        if (is_div_r) begin
            fix_hi_s = rem_s;
            fix_lo_s = dbz_r ? {WIDTH{1'b1}} : quot_s;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer, operand latch and HI/LO registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            b_mag_r  <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                b_mag_r  <= b_mag_s;
                                is_div_r <= (op == OP_DIV) || (op == OP_DIVU);
                                sign_q_r <= signed_s && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                sign_r_r <= signed_s && src_a[WIDTH-1];
                                dbz_r    <= (src_b == {WIDTH{1'b0}});
                                cnt_r    <= {CNT_W{1'b0}};
                                busy_r   <= 1'b1;
                                state_r  <= ST_RUN;
                            end
                            OP_MTHI: hi_r <= src_a;
                            OP_MTLO: lo_r <= src_a;
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(ITER - 1)) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at the current negedge, let edge N sample it, then
    // scramble the operands (only the latched copies may be used).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; src_a = 32'hDEADBEEF; src_b = 32'h0BADF00D;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_low_after_start", {31'd0, done}, 32'd0);
    endtask

    // Count remaining busy cycles, then expect the done pulse (bounded wait).
    task automatic wait_done(input string tag, input int exp_busy);
        int n = 0;
        while (busy && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // MULT -3 * 7 = -21
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        wait_done("mult", 33);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        // MULTU in the done cycle; extra start mid-run must be ignored
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd2; src_a = 32'd9; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("multu_hold_hi", hi, 32'hFFFFFFFF);
        chk("multu_hold_lo", lo, 32'hFFFFFFEB);
        wait_done("multu", 29);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        // DIV -7 / 2 = -3 rem -1
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done("div", 33);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_lo", lo, 32'hFFFFFFFD);

        // DIV overflow wraps
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 33);
        chk("div_ovf_hi", hi, 32'h00000000);
        chk("div_ovf_lo", lo, 32'h80000000);

        // DIVU by zero
        issue(3'd3, 32'd100, 32'd0);
        wait_done("divu_z", 33);
        chk("divu_z_hi", hi, 32'h00000064);
        chk("divu_z_lo", lo, 32'hFFFFFFFF);

        // DIV by zero, negative dividend
        issue(3'd2, 32'hFFFFFFFB, 32'd0);
        wait_done("div_z", 33);
        chk("div_z_hi", hi, 32'hFFFFFFFB);
        chk("div_z_lo", lo, 32'hFFFFFFFF);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = 3'd4; src_a = 32'h12345678;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo_keep", lo, 32'hFFFFFFFF);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd5; src_a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi_keep", hi, 32'h12345678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_done", {31'd0, done}, 32'd0);

        // Reserved op 6 is ignored
        start = 1'b1; op = 3'd6; src_a = 32'h55555555; src_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("op6_busy", {31'd0, busy}, 32'd0);
        chk("op6_hi", hi, 32'h12345678);
        chk("op6_lo", lo, 32'h9ABCDEF0);

        // Reset in the middle of DIVU 1000/3
        issue(3'd3, 32'd1000, 32'd3);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) seen++;
                @(negedge clk);
            end
            chk("midrst_no_done", 32'(seen), 32'd0);
        end

        // Fresh MULTU 6 * 7
        issue(3'd1, 32'd6, 32'd7);
        wait_done("multu67", 33);
        chk("multu67_hi", hi, 32'd0);
        chk("multu67_lo", lo, 32'd42);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
